// File: rtl/add_share_arb.sv
// -----------------------------------------------------------------------------
// add_share_arb
//   Shares one pipelined W-bit adder among N requesters. Each cycle at most one
//   requester is granted. Its operands are steered to the adder and its ID is
//   pushed into a LAT-deep tag pipe that runs in lockstep with the adder. When
//   a tag leaves the pipe, the adder result and that ID are registered onto the
//   response port. A drain input stops new grants and lets in-flight ops finish.
//
// Configuration macro:
//   ADD_SHARE_ARB_FIXED_PRIO_EN - when defined, the lowest asserted index wins
//                                 and the round-robin pointer does not exist.
//                                 When undefined (default), arbitration is
//                                 round-robin.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req[N]            requester i has operands valid; held until granted
//   req_a/req_b[N*W]  operands, requester i at [i*W +: W]
//   gnt[N]            one-hot grant (combinational); transfer on req&gnt
//   drain             stop issuing; in-flight ops still complete
//   add_start/a/b     adder issue interface (a/b are 0 when nothing granted)
//   add_y[W]          adder result, valid LAT cycles after start
//   rsp_valid/id/y    registered response, one-cycle pulse per op
//   idle              registered: FSM idle and no op in flight
// -----------------------------------------------------------------------------
module add_share_arb #(
   parameter int W   = 8,
   parameter int N   = 4,
   parameter int LAT = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*W-1:0]  req_a,
   input  logic [N*W-1:0]  req_b,
   output logic [N-1:0]    gnt,
   input  logic            drain,
   output logic            add_start,
   output logic [W-1:0]    add_a,
   output logic [W-1:0]    add_b,
   input  logic [W-1:0]    add_y,
   output logic            rsp_valid,
   output logic [IW-1:0]   rsp_id,
   output logic [W-1:0]    rsp_y,
   output logic            idle
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [LAT-1:0]          tag_vld_q, tag_vld_d;
   logic [LAT-1:0][IW-1:0]  tag_id_q, tag_id_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [IW-1:0]           rsp_id_q, rsp_id_d;
   logic [W-1:0]            rsp_y_q, rsp_y_d;
   logic                    idle_q, idle_d;

   logic                    win_vld;
   logic [IW-1:0]           win_id;
   logic                    issue_ok;
   logic                    in_flight;

`ifndef ADD_SHARE_ARB_FIXED_PRIO_EN
   logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]           idx;
`endif

   assign in_flight = |tag_vld_q;
   // Grants only from IDLE/RUN with drain low; drain wins over a pending req.
   assign issue_ok  = !drain && (state_q != S_DRAIN);

   // ---------------- winner selection ----------------
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
`ifdef ADD_SHARE_ARB_FIXED_PRIO_EN
      // Scan downward so the lowest asserted index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_vld = 1'b1;
            win_id  = IW'(i);
         end
      end
`else
      idx = '0;
      // Search rr_ptr, rr_ptr+1, ... modulo N; the first hit wins.
      for (int i = 0; i < N; i++) begin
         idx = IW'((int'(rr_ptr_q) + i) % N);
         if (!win_vld && req[idx]) begin
            win_vld = 1'b1;
            win_id  = idx;
         end
      end
`endif
   end

   // ---------------- grant and adder issue ----------------
   always_comb begin
      gnt   = '0;
      add_a = '0;
      add_b = '0;
      if (issue_ok && win_vld) gnt[win_id] = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) begin
            add_a = req_a[i*W +: W];
            add_b = req_b[i*W +: W];
         end
      end
   end

   assign add_start = |gnt;

`ifndef ADD_SHARE_ARB_FIXED_PRIO_EN
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (add_start) rr_ptr_d = (win_id == IW'(N - 1)) ? '0 : win_id + 1'b1;
   end
`endif

   // ---------------- tag pipe and response ----------------
   // The pipe shifts every cycle regardless of activity, so a tag lines up
   // exactly with add_y LAT cycles after its start.
   always_comb begin
      tag_vld_d    = tag_vld_q;
      tag_id_d     = tag_id_q;
      tag_vld_d[0] = add_start;
      tag_id_d[0]  = win_id;
      for (int s = 1; s < LAT; s++) begin
         tag_vld_d[s] = tag_vld_q[s-1];
         tag_id_d[s]  = tag_id_q[s-1];
      end

      rsp_valid_d = tag_vld_q[LAT-1];
      rsp_id_d    = rsp_id_q;
      rsp_y_d     = rsp_y_q;
      if (tag_vld_q[LAT-1]) begin
         rsp_id_d = tag_id_q[LAT-1];
         rsp_y_d  = add_y;
      end
   end

   // ---------------- FSM ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (|req && !drain) state_d = S_RUN;
         S_RUN: begin
            if (drain)                         state_d = S_DRAIN;
            else if (!(|req) && !in_flight)    state_d = S_IDLE;
         end
         S_DRAIN: begin
            if (!in_flight)                    state_d = S_IDLE;
            else if (!drain)                   state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
      idle_d = (state_d == S_IDLE) && !(|tag_vld_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         tag_vld_q   <= '0;
         tag_id_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_y_q     <= '0;
         idle_q      <= 1'b1;
`ifndef ADD_SHARE_ARB_FIXED_PRIO_EN
         rr_ptr_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         tag_vld_q   <= tag_vld_d;
         tag_id_q    <= tag_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_y_q     <= rsp_y_d;
         idle_q      <= idle_d;
`ifndef ADD_SHARE_ARB_FIXED_PRIO_EN
         rr_ptr_q    <= rr_ptr_d;
`endif
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_y     = rsp_y_q;
   assign idle      = idle_q;

endmodule

// File: tb/tb_add_share_arb.sv
// Directed bench for add_share_arb (default round-robin build). A behavioural
// LAT-stage adder sits on the adder port; every grant pushes the expected
// {id, sum, cycle} onto a scoreboard that a negedge monitor pops against
// rsp_*.
module tb_add_share_arb;
   localparam int W   = 8;
   localparam int N   = 4;
   localparam int LAT = 2;
   localparam int IW  = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*W-1:0]  req_a, req_b;
   logic [N-1:0]    gnt;
   logic            drain;
   logic            add_start;
   logic [W-1:0]    add_a, add_b, add_y;
   logic            rsp_valid;
   logic [IW-1:0]   rsp_id;
   logic [W-1:0]    rsp_y;
   logic            idle;

   add_share_arb #(.W(W), .N(N), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
      .gnt(gnt), .drain(drain), .add_start(add_start), .add_a(add_a),
      .add_b(add_b), .add_y(add_y), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_y(rsp_y), .idle(idle)
   );

   always #5 clk = ~clk;

   // Behavioural adder: start in cycle k -> sum on add_y in cycle k+2.
   logic [W-1:0] s1 = '0, s2 = '0;
   always @(posedge clk) begin
      s1 <= add_a + add_b;
      s2 <= s1;
   end
   assign add_y = s2;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [IW-1:0] id;
      logic [W-1:0]  y;
      int            cyc;
   } exp_t;
   exp_t exp_q[$];

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] opa [N];
   logic [W-1:0] opb [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      opa[i] = a;
      opb[i] = b;
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   // One cycle with the inputs already driven: check grant/issue at negedge,
   // record the expected response, then move to just after the next posedge.
   task automatic step(input string tag, input logic [N-1:0] exp_gnt);
      int w;
      exp_t e;
      logic [W-1:0] ea, eb;
      @(negedge clk);
      w  = -1;
      ea = '0;
      eb = '0;
      for (int i = 0; i < N; i++) if (exp_gnt[i]) w = i;
      if (w >= 0) begin
         ea = opa[w];
         eb = opb[w];
      end
      chk({tag, "_gnt"},   32'(gnt),       32'(exp_gnt));
      chk({tag, "_start"}, 32'(add_start), 32'(|exp_gnt));
      chk({tag, "_a"},     32'(add_a),     32'(ea));
      chk({tag, "_b"},     32'(add_b),     32'(eb));
      if (w >= 0) begin
         e.id  = IW'(w);
         e.y   = ea + eb;
         e.cyc = cyc + LAT + 1;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 4'b0000);
   endtask

   // Response monitor: every rsp_valid must match the head of the scoreboard,
   // in the predicted cycle; a head entry whose cycle passes is a miss.
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid !== 1'b0) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL rsp_unexpected observed id=%0h y=%0h expected=none", rsp_id, rsp_y);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_id",  32'(rsp_id), 32'(e.id));
            chk("rsp_y",   32'(rsp_y),  32'(e.y));
            chk("rsp_cyc", 32'(cyc),    32'(e.cyc));
         end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         chk("rsp_missing", 32'(rsp_valid), 32'(1));
      end
   end

   initial begin
      rst   = 1'b1;
      req   = '0;
      drain = 1'b0;
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < N; i++) begin
         opa[i] = '0;
         opb[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      // reset state
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rsp_id",    32'(rsp_id),    32'(0));
      chk("rst_rsp_y",     32'(rsp_y),     32'(0));
      chk("rst_idle",      32'(idle),      32'(1));
      rst = 1'b0;
      quiet("rst_quiet", 2);

      // single op, granted in the request cycle
      set_op(2, 8'h12, 8'h34);
      req = 4'b0100;
      step("t1", 4'b0100);
      req = 4'b0000;
      quiet("t1_q", 5);
      chk("t1_idle", 32'(idle), 32'(1));

      // pointer wrap (ptr=3): 3 then 0; then ptr=1 picks 1 over 0
      set_op(0, 8'h05, 8'h06);
      set_op(3, 8'h07, 8'h08);
      set_op(1, 8'h21, 8'h22);
      req = 4'b1001; step("t6_g3", 4'b1000);
      req = 4'b0001; step("t6_g0", 4'b0001);
      req = 4'b0011; step("t6_ptr1", 4'b0010);
      req = 4'b1000; step("t6_g3b", 4'b1000);
      req = 4'b0000;
      quiet("t6_q", 5);

      // all four held from ptr=0: 0,1,2,3,0 back-to-back
      set_op(0, 8'h01, 8'h02);
      set_op(1, 8'h10, 8'h20);
      set_op(2, 8'h33, 8'h44);
      set_op(3, 8'hA0, 8'h70);
      req = 4'b1111;
      step("t2_0", 4'b0001);
      step("t2_1", 4'b0010);
      step("t2_2", 4'b0100);
      step("t2_3", 4'b1000);
      step("t2_0b", 4'b0001);
      req = 4'b0000;
      quiet("t2_q", 6);

      // overflow wraps (ptr=1)
      set_op(1, 8'hFF, 8'h01);
      req = 4'b0010; step("t3_ff", 4'b0010);
      set_op(2, 8'h80, 8'h80);
      req = 4'b0100; step("t3_80", 4'b0100);
      req = 4'b0000;
      quiet("t3_q", 5);

      // drain after two grants with req[1] pending (ptr=3)
      set_op(3, 8'h11, 8'h22);
      set_op(0, 8'h33, 8'h44);
      set_op(1, 8'h55, 8'h66);
      req = 4'b1011; step("t4_g3", 4'b1000);
      req = 4'b0011; step("t4_g0", 4'b0001);
      drain = 1'b1;
      req = 4'b0010;
      quiet("t4_drain", 5);
      chk("t4_idle", 32'(idle), 32'(1));
      drain = 1'b0;
      step("t4_resume", 4'b0010);
      req = 4'b0000;
      quiet("t4_q", 5);

      // reset one cycle after a grant (ptr=2 -> grant 1)
      set_op(1, 8'h0A, 8'h0B);
      req = 4'b0010;
      step("t5_issue", 4'b0010);
      rst = 1'b1;
      req = 4'b0000;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t5_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("t5_rsp_id",    32'(rsp_id),    32'(0));
      chk("t5_rsp_y",     32'(rsp_y),     32'(0));
      chk("t5_idle",      32'(idle),      32'(1));
      quiet("t5_q", 4);
      req = 4'b1111;
      step("t5_ptr0", 4'b0001);
      req = 4'b0000;
      quiet("t5_q2", 5);

      chk("sb_empty", 32'(exp_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
